// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: pipelined signed pre-add / multiply / post-add slice with
// optional multiplier register, saturating or wrapping accumulator, per-sample
// valid tracking and a saturating term counter. pcout mirrors p for cascading.
module dsp_mac_pipe #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int P_WIDTH   = 48,
  parameter int MREG      = 1,
  parameter int SATURATE  = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic [B_WIDTH-1:0]   d,
  input  logic [P_WIDTH-1:0]   c,
  input  logic [3:0]           opmode,
  output logic [P_WIDTH-1:0]   p,
  output logic [P_WIDTH-1:0]   pcout,
  output logic                 p_valid,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] acc_count
);

  localparam int PRE_W = B_WIDTH + 1;
  localparam int M_W   = A_WIDTH + B_WIDTH + 1;

  // ---------------- S1: input registers ----------------
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [B_WIDTH-1:0] b_q, b_d, d_q, d_d;
  logic [P_WIDTH-1:0] c_q, c_d;
  logic [3:0]         op_q, op_d;
  logic               v1_q, v1_d;

  // S1 next state: capture inputs when enabled, otherwise hold
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    d_d  = d_q;
    c_d  = c_q;
    op_d = op_q;
    v1_d = v1_q;
    if (ce) begin
      a_d  = a;
      b_d  = b;
      d_d  = d;
      c_d  = c;
      op_d = opmode;
      v1_d = in_valid;
    end
  end

  // S1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      d_q  <= '0;
      c_q  <= '0;
      op_q <= '0;
      v1_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      d_q  <= d_d;
      c_q  <= c_d;
      op_q <= op_d;
      v1_q <= v1_d;
    end
  end

  // ---------------- pre-adder and multiplier ----------------
  logic [PRE_W-1:0] pre, b_x, d_x;
  logic [M_W-1:0]   pre_m, a_m, prod;

  // Operands are sign-extended to the full product width so an unsigned
  // multiply yields the correct two's-complement low bits.
  always_comb begin
    b_x = {b_q[B_WIDTH-1], b_q};
    d_x = {d_q[B_WIDTH-1], d_q};
    if (op_q[0]) pre = op_q[1] ? (d_x - b_x) : (d_x + b_x);
    else         pre = b_x;
    pre_m = {{(M_W-PRE_W){pre[PRE_W-1]}}, pre};
    a_m   = {{(M_W-A_WIDTH){a_q[A_WIDTH-1]}}, a_q};
    prod  = pre_m * a_m;
  end

  // ---------------- optional S2: multiplier register ----------------
  logic [M_W-1:0]     m_prod;
  logic [P_WIDTH-1:0] m_c;
  logic               m_acc, m_psub, m_v;

  if (MREG != 0) begin : g_mreg
    logic [M_W-1:0]     prod_q, prod_d;
    logic [P_WIDTH-1:0] c2_q, c2_d;
    logic [1:0]         op2_q, op2_d;
    logic               v2_q, v2_d;

    // S2 next state: advance only when enabled
    always_comb begin
      prod_d = prod_q;
      c2_d   = c2_q;
      op2_d  = op2_q;
      v2_d   = v2_q;
      if (ce) begin
        prod_d = prod;
        c2_d   = c_q;
        op2_d  = op_q[3:2];
        v2_d   = v1_q;
      end
    end

    // S2 registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_q <= '0;
        c2_q   <= '0;
        op2_q  <= '0;
        v2_q   <= 1'b0;
      end else begin
        prod_q <= prod_d;
        c2_q   <= c2_d;
        op2_q  <= op2_d;
        v2_q   <= v2_d;
      end
    end

    assign m_prod = prod_q;
    assign m_c    = c2_q;
    assign m_acc  = op2_q[0];
    assign m_psub = op2_q[1];
    assign m_v    = v2_q;
  end else begin : g_no_mreg
    assign m_prod = prod;
    assign m_c    = c_q;
    assign m_acc  = op_q[2];
    assign m_psub = op_q[3];
    assign m_v    = v1_q;
  end

  // ---------------- S3: post-adder and P register ----------------
  logic [P_WIDTH-1:0]   p_q, p_d, base;
  logic [P_WIDTH:0]     base_x, prod_x, res;
  logic                 ovf_q, ovf_d, res_ovf;
  logic                 pv_q, pv_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // S3 next state: the accumulate path feeds back p_q directly, so
  // back-to-back accumulating samples each see the previous result.
  always_comb begin
    base    = m_acc ? p_q : m_c;
    base_x  = {base[P_WIDTH-1], base};
    prod_x  = {{(P_WIDTH+1-M_W){m_prod[M_W-1]}}, m_prod};
    res     = m_psub ? (base_x - prod_x) : (base_x + prod_x);
    res_ovf = res[P_WIDTH] ^ res[P_WIDTH-1];
    p_d     = p_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    pv_d    = ce & m_v;
    if (ce && m_v) begin
      ovf_d = res_ovf;
      if (res_ovf && (SATURATE != 0))
        p_d = res[P_WIDTH] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}};
      else
        p_d = res[P_WIDTH-1:0];
      if (!m_acc)            cnt_d = CNT_WIDTH'(1);
      else if (cnt_q != '1)  cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // S3 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q   <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      pv_q  <= 1'b0;
    end else begin
      p_q   <= p_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
      pv_q  <= pv_d;
    end
  end

  assign p         = p_q;
  assign pcout     = p_q;
  assign p_valid   = pv_q;
  assign ovf       = ovf_q;
  assign acc_count = cnt_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: three instances (defaults, wrap mode, no multiplier
// register) share one stimulus stream; a per-instance queue holds expected
// results with their due cycle.
module tb_dsp_mac_pipe;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ce = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [17:0] a = '0, b = '0, d = '0;
  logic signed [47:0] c = '0;
  logic [3:0]         opmode = '0;

  logic signed [47:0] p_o [3];
  logic signed [47:0] pc_o [3];
  logic               pv_o [3];
  logic               ov_o [3];
  logic [7:0]         cnt_o [3];

  always #5 clk = ~clk;

  dsp_mac_pipe #(.MREG(1), .SATURATE(1)) u_main (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .d(d), .c(c),
    .opmode(opmode), .p(p_o[0]), .pcout(pc_o[0]), .p_valid(pv_o[0]), .ovf(ov_o[0]),
    .acc_count(cnt_o[0]));

  dsp_mac_pipe #(.MREG(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .d(d), .c(c),
    .opmode(opmode), .p(p_o[1]), .pcout(pc_o[1]), .p_valid(pv_o[1]), .ovf(ov_o[1]),
    .acc_count(cnt_o[1]));

  dsp_mac_pipe #(.MREG(0), .SATURATE(1)) u_m0 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .d(d), .c(c),
    .opmode(opmode), .p(p_o[2]), .pcout(pc_o[2]), .p_valid(pv_o[2]), .ovf(ov_o[2]),
    .acc_count(cnt_o[2]));

  typedef struct {
    logic signed [47:0] p;
    logic               ovf;
    logic [7:0]         cnt;
    int                 due;
  } exp_t;

  typedef struct {
    logic [3:0]         op;
    logic signed [17:0] a, b, d;
    logic signed [47:0] c;
    logic               iv;
    logic signed [47:0] ep;
    logic               eo;
    logic [7:0]         ec;
    logic signed [47:0] epw;
    logic               eow;
  } vec_t;

  exp_t               q [3][$];
  logic signed [47:0] last_p [3];
  logic               last_o [3];
  logic [7:0]         last_c [3];
  int                 pulses [3];
  int                 cyc = 0;
  int                 nvec = 0;
  int                 nfail = 0;

  localparam logic signed [47:0] MAXV = {1'b0, {47{1'b1}}};
  localparam logic signed [47:0] MINV = {1'b1, {47{1'b0}}};

  initial begin
    for (int k = 0; k < 3; k++) begin
      last_p[k] = '0; last_o[k] = 1'b0; last_c[k] = '0; pulses[k] = 0;
    end
  end

  task automatic check_dut(input int k);
    exp_t e;
    if (pv_o[k]) begin
      pulses[k]++;
      nvec++;
      if (q[k].size() == 0) begin
        nfail++;
        $display("FAIL unexpected_pv dut%0d cyc=%0d got p=%0d", k, cyc, p_o[k]);
      end else begin
        e = q[k].pop_front();
        if (cyc != e.due || p_o[k] != e.p || pc_o[k] != e.p || ov_o[k] != e.ovf || cnt_o[k] != e.cnt) begin
          nfail++;
          $display("FAIL result dut%0d: got cyc=%0d p=%0d pcout=%0d ovf=%0b cnt=%0d, want cyc=%0d p=%0d ovf=%0b cnt=%0d",
                   k, cyc, p_o[k], pc_o[k], ov_o[k], cnt_o[k], e.due, e.p, e.ovf, e.cnt);
        end
        last_p[k] = e.p; last_o[k] = e.ovf; last_c[k] = e.cnt;
      end
    end else begin
      nvec++;
      if (p_o[k] != last_p[k] || ov_o[k] != last_o[k] || cnt_o[k] != last_c[k]) begin
        nfail++;
        $display("FAIL hold dut%0d cyc=%0d: got p=%0d ovf=%0b cnt=%0d, want p=%0d ovf=%0b cnt=%0d",
                 k, cyc, p_o[k], ov_o[k], cnt_o[k], last_p[k], last_o[k], last_c[k]);
      end
      if (q[k].size() != 0 && q[k][0].due < cyc) begin
        nvec++;
        nfail++;
        e = q[k].pop_front();
        $display("FAIL missing_pv dut%0d cyc=%0d: got p_valid=0, want p=%0d by cyc=%0d", k, cyc, e.p, e.due);
      end
    end
  endtask

  // Cycle counter, ce-stall bookkeeping and output checking
  always @(posedge clk) begin
    cyc++;
    if (!ce && !rst)
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < q[k].size(); i++)
          q[k][i].due = q[k][i].due + 1;
    #1;
    for (int k = 0; k < 3; k++) check_dut(k);
  end

  task automatic send(input logic [3:0] op, input logic signed [17:0] av, bv, dv,
                      input logic signed [47:0] cv, input logic iv, cev,
                      input logic signed [47:0] ep, input logic eo, input logic [7:0] ec,
                      input logic signed [47:0] epw, input logic eow);
    exp_t e;
    @(negedge clk);
    opmode = op; a = av; b = bv; d = dv; c = cv; in_valid = iv; ce = cev;
    if (iv && cev && !rst) begin
      e.p = ep;  e.ovf = eo;  e.cnt = ec; e.due = cyc + 3; q[0].push_back(e);
      e.p = epw; e.ovf = eow;                              q[1].push_back(e);
      e.p = ep;  e.ovf = eo;               e.due = cyc + 2; q[2].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(4'b0000, 0, 0, 0, 0, 1'b0, 1'b1, 0, 1'b0, 8'd0, 0, 1'b0);
  endtask

  task automatic flush_model();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      last_p[k] = '0; last_o[k] = 1'b0; last_c[k] = '0;
    end
  endtask

  task automatic check_zero(input string name);
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (p_o[k] != 0 || pc_o[k] != 0 || pv_o[k] != 1'b0 || ov_o[k] != 1'b0 || cnt_o[k] != 0) begin
        nfail++;
        $display("FAIL %s dut%0d: got p=%0d pcout=%0d pv=%0b ovf=%0b cnt=%0d, want all zero",
                 name, k, p_o[k], pc_o[k], pv_o[k], ov_o[k], cnt_o[k]);
      end
    end
  endtask

  vec_t tbl [20];
  int   pbase;

  initial begin
    //        op       a        b        d        c               iv    p                 ovf   cnt  p(wrap)           ovf(wrap)
    tbl[0]  = '{4'b0100, 3,       3,       0,       0,              1'b1, 9,                1'b0, 1,  9,                1'b0};
    tbl[1]  = '{4'b0001, 3,       4,       10,      100,            1'b1, 142,              1'b0, 1,  142,              1'b0};
    tbl[2]  = '{4'b0000, 2,       5,       0,       0,              1'b1, 10,               1'b0, 1,  10,               1'b0};
    tbl[3]  = '{4'b0100, 2,       5,       0,       0,              1'b1, 20,               1'b0, 2,  20,               1'b0};
    tbl[4]  = '{4'b0100, 2,       5,       0,       0,              1'b1, 30,               1'b0, 3,  30,               1'b0};
    tbl[5]  = '{4'b0100, 2,       5,       0,       0,              1'b1, 40,               1'b0, 4,  40,               1'b0};
    tbl[6]  = '{4'b0100, 2,       5,       0,       0,              1'b0, 0,                1'b0, 0,  0,                1'b0};
    tbl[7]  = '{4'b1100, 2,       5,       0,       0,              1'b1, 30,               1'b0, 5,  30,               1'b0};
    tbl[8]  = '{4'b1000, -3,      7,       0,       50,             1'b1, 71,               1'b0, 1,  71,               1'b0};
    tbl[9]  = '{4'b0011, -3,      7,       5,       0,              1'b1, 6,                1'b0, 1,  6,                1'b0};
    tbl[10] = '{4'b0000, 1,       1,       0,       MAXV,           1'b1, MAXV,             1'b1, 1,  MINV,             1'b1};
    tbl[11] = '{4'b1000, 1,       1,       0,       MAXV,           1'b1, MAXV - 48'sd1,    1'b0, 1,  MAXV - 48'sd1,    1'b0};
    tbl[12] = '{4'b1000, 1,       1,       0,       MINV,           1'b1, MINV,             1'b1, 1,  MAXV,             1'b1};
    tbl[13] = '{4'b0100, -1,      1,       0,       0,              1'b1, MINV,             1'b1, 2,  MAXV - 48'sd1,    1'b0};
    tbl[14] = '{4'b1100, -1,      1,       0,       0,              1'b1, MINV + 48'sd1,    1'b0, 3,  MAXV,             1'b0};
    tbl[15] = '{4'b0100, 1,       1,       0,       0,              1'b1, MINV + 48'sd2,    1'b0, 4,  MINV,             1'b1};
    tbl[16] = '{4'b0000, -131072, -131072, 0,       0,              1'b1, 48'sd17179869184, 1'b0, 1,  48'sd17179869184, 1'b0};
    tbl[17] = '{4'b0011, -131072, 131071,  -131072, 0,              1'b1, 48'sd34359607296, 1'b0, 1,  48'sd34359607296, 1'b0};
    tbl[18] = '{4'b0001, -131072, -131072, -131072, -48'sd1,        1'b1, 48'sd34359738367, 1'b0, 1,  48'sd34359738367, 1'b0};
    tbl[19] = '{4'b1111, 1000,    1,       100,     0,              1'b1, 48'sd34359639367, 1'b0, 2,  48'sd34359639367, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    // table vectors, back to back
    for (int i = 0; i < 20; i++)
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].c, tbl[i].iv, 1'b1,
           tbl[i].ep, tbl[i].eo, tbl[i].ec, tbl[i].epw, tbl[i].eow);
    idle(4);

    // term counter saturates at 255
    send(4'b0000, 0, 0, 0, 7, 1'b1, 1'b1, 7, 1'b0, 8'd1, 7, 1'b0);
    for (int i = 0; i < 260; i++)
      send(4'b0100, 0, 0, 0, 0, 1'b1, 1'b1, 7, 1'b0, (i + 2 > 255) ? 8'd255 : 8'(i + 2), 7, 1'b0);
    idle(4);

    // ce stalls with samples in flight; in_valid during ce=0 is ignored
    pbase = pulses[0];
    send(4'b0000, 3, 3, 0, 1,  1'b1, 1'b1, 10, 1'b0, 8'd1, 10, 1'b0);
    send(4'b0000, 100, 1, 0, 0, 1'b1, 1'b0, 0, 1'b0, 8'd0, 0, 1'b0);
    send(4'b0000, 100, 1, 0, 0, 1'b1, 1'b0, 0, 1'b0, 8'd0, 0, 1'b0);
    send(4'b0000, 0, 0, 0, 0,  1'b0, 1'b1, 0, 1'b0, 8'd0, 0, 1'b0);
    send(4'b0100, 1, 1, 0, 0,  1'b1, 1'b1, 11, 1'b0, 8'd2, 11, 1'b0);
    send(4'b0000, 100, 1, 0, 0, 1'b1, 1'b0, 0, 1'b0, 8'd0, 0, 1'b0);
    send(4'b0000, 100, 1, 0, 0, 1'b1, 1'b0, 0, 1'b0, 8'd0, 0, 1'b0);
    idle(6);
    nvec++;
    if (pulses[0] - pbase != 2) begin
      nfail++;
      $display("FAIL stall_pulses: got %0d p_valid pulses, want 2", pulses[0] - pbase);
    end

    // asynchronous reset with two samples in flight, in_valid held during reset
    send(4'b0000, 1, 1, 0, 5, 1'b1, 1'b1, 6, 1'b0, 8'd1, 6, 1'b0);
    send(4'b0100, 1, 1, 0, 0, 1'b1, 1'b1, 7, 1'b0, 8'd2, 7, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    flush_model();
    #1;
    check_zero("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    pbase = pulses[0] + pulses[1] + pulses[2];
    idle(5);
    nvec++;
    if (pulses[0] + pulses[1] + pulses[2] != pbase) begin
      nfail++;
      $display("FAIL post_reset_pv: got %0d pulses, want 0", pulses[0] + pulses[1] + pulses[2] - pbase);
    end

    // fresh samples after reset
    send(4'b0001, 3, 4, 10, 100, 1'b1, 1'b1, 142, 1'b0, 8'd1, 142, 1'b0);
    send(4'b0100, 3, 3, 0, 0,    1'b1, 1'b1, 151, 1'b0, 8'd2, 151, 1'b0);
    idle(6);

    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (q[k].size() != 0) begin
        nfail++;
        $display("FAIL drain dut%0d: got %0d results outstanding, want 0", k, q[k].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
